// File: rtl/sfifo_wconv_pkg.sv
// Shared helpers for the single-clock width-converting prefetch FIFO.
// Parameter legality checks and derived-width functions live here.
package sfifo_wconv_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit ratio_legal(input int unsigned r);
    return (r == 1) || (r == 2) || (r == 4);
  endfunction

  function automatic bit depth_legal(input int unsigned d);
    return (d >= 2) && (d <= 14);
  endfunction

  function automatic int unsigned rd_width(input int unsigned w, input int unsigned r);
    return w * r;
  endfunction

  function automatic int unsigned level_width(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/sfifo_wconv_prefetch_if.sv
// Write/read handshake bundle for sfifo_wconv_prefetch.
// slave = FIFO side, master = producer/consumer side.
interface sfifo_wconv_prefetch_if
  import sfifo_wconv_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH = 16,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned DEPTH_WIDTH   = 10
);
  localparam int unsigned RdW  = rd_width(WR_DATA_WIDTH, RATIO);
  localparam int unsigned LvlW = level_width(DEPTH_WIDTH);

  logic                     wr_en;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_vld;
  logic                     rd_en;
  logic [RdW-1:0]           rd_data;
  logic                     rd_vld;
  logic [LvlW-1:0]          level;
  logic                     almost_full;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_vld, rd_data, rd_vld, level, almost_full
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_vld, rd_data, rd_vld, level, almost_full
  );
endinterface

// File: rtl/sfifo_wconv_packer.sv
// Narrow-to-wide assembler: first accepted word lands in the LSBs, and the
// RATIO-th word produces a one-cycle push strobe with the complete wide word.
module sfifo_wconv_packer
  import sfifo_wconv_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH = 16,
  parameter int unsigned RATIO         = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic                                  wr_i,
  input  logic [WR_DATA_WIDTH-1:0]              data_i,
  output logic                                  push_o,
  output logic [rd_width(WR_DATA_WIDTH, RATIO)-1:0] word_o
);
  localparam int unsigned RdW  = rd_width(WR_DATA_WIDTH, RATIO);
  localparam int unsigned CntW = (RATIO > 1) ? clog2(RATIO) : 1;

  logic [CntW-1:0] pk_cnt_q, pk_cnt_d;
  logic [RdW-1:0]  hold_q, hold_d;
  logic            last;

  // With RATIO=1 the counter is pinned at 0, so every write completes a word.
  assign last   = (pk_cnt_q == CntW'(RATIO - 1));
  assign push_o = wr_i && last && !flush_i;

  always_comb begin
    pk_cnt_d = pk_cnt_q;
    hold_d   = hold_q;
    word_o   = hold_q;
    word_o[pk_cnt_q*WR_DATA_WIDTH +: WR_DATA_WIDTH] = data_i;
    if (flush_i) begin
      pk_cnt_d = '0;
    end else if (wr_i) begin
      pk_cnt_d = last ? '0 : pk_cnt_q + 1'b1;
      hold_d   = word_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_cnt_q <= '0;
      hold_q   <= '0;
    end else begin
      pk_cnt_q <= pk_cnt_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/sfifo_wconv_prefetch.sv
// Single-clock FWFT FIFO with 1:RATIO narrow-to-wide packing, a RAM ring of
// 2**DEPTH_WIDTH-1 wide words and one prefetch output register.
// Optional synchronous flush port enabled by SFIFO_WCONV_FLUSH_EN.
module sfifo_wconv_prefetch
  import sfifo_wconv_pkg::*;
#(
  parameter int unsigned WR_DATA_WIDTH = 16,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned DEPTH_WIDTH   = 10,
  parameter int unsigned AF_THRESH     = 2**DEPTH_WIDTH - 4
) (
  input logic clk,
  input logic rst_n,
`ifdef SFIFO_WCONV_FLUSH_EN
  input logic flush,
`endif
  sfifo_wconv_prefetch_if.slave bus
);
  localparam int unsigned RD_DATA_WIDTH = rd_width(WR_DATA_WIDTH, RATIO);
  localparam int unsigned LvlW          = level_width(DEPTH_WIDTH);
  localparam int unsigned Cap           = 2**DEPTH_WIDTH;
  localparam int unsigned RamDepth      = Cap - 1;
  localparam logic [DEPTH_WIDTH-1:0] PtrLast = DEPTH_WIDTH'(RamDepth - 1);

  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("sfifo_wconv_prefetch: RATIO must be 1, 2 or 4");
  end
  if (!depth_legal(DEPTH_WIDTH)) begin : g_bad_depth
    $error("sfifo_wconv_prefetch: DEPTH_WIDTH must be in 2..14");
  end

  logic flush_w;
`ifdef SFIFO_WCONV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [RD_DATA_WIDTH-1:0] mem_q [RamDepth];
  logic [DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH-1:0]   ram_cnt_q, ram_cnt_d;
  logic                     out_vld_q, out_vld_d;
  logic [RD_DATA_WIDTH-1:0] out_data_q;
  logic [LvlW-1:0]          level_q, level_d;
  logic                     wr_vld_q, wr_vld_d;
  logic                     af_q, af_d;

  logic                     wr_acc, push, pop, load;
  logic [RD_DATA_WIDTH-1:0] push_word;

  function automatic logic [DEPTH_WIDTH-1:0] ptr_inc(input logic [DEPTH_WIDTH-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign wr_acc = bus.wr_en && wr_vld_q && !flush_w;
  assign pop    = bus.rd_en && out_vld_q && !flush_w;
  // Refill the output register whenever it is (or is about to be) empty.
  assign load   = (ram_cnt_q != '0) && (!out_vld_q || pop) && !flush_w;

  sfifo_wconv_packer #(
    .WR_DATA_WIDTH (WR_DATA_WIDTH),
    .RATIO         (RATIO)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_w),
    .wr_i    (wr_acc),
    .data_i  (bus.wr_data),
    .push_o  (push),
    .word_o  (push_word)
  );

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = load ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + DEPTH_WIDTH'(push) - DEPTH_WIDTH'(load);
    out_vld_d = load ? 1'b1 : (pop ? 1'b0 : out_vld_q);
    if (flush_w) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      out_vld_d = 1'b0;
    end
    level_d  = LvlW'(ram_cnt_d) + LvlW'(out_vld_d);
    wr_vld_d = !flush_w && (level_d < LvlW'(Cap));
    af_d     = (level_d >= LvlW'(AF_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      level_q    <= '0;
      wr_vld_q   <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      out_vld_q <= out_vld_d;
      level_q   <= level_d;
      wr_vld_q  <= wr_vld_d;
      af_q      <= af_d;
      if (load) out_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign bus.wr_vld      = wr_vld_q;
  assign bus.rd_vld      = out_vld_q;
  assign bus.rd_data     = out_data_q;
  assign bus.level       = level_q;
  assign bus.almost_full = af_q;

endmodule

// File: tb/tb_sfifo_wconv_prefetch.sv
// Directed self-checking bench: three FIFO configurations (1:2 depth 4,
// 1:4 depth 4, 1:1 depth 4) sharing one clock and reset.
module tb_sfifo_wconv_prefetch;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sfifo_wconv_prefetch_if #(.WR_DATA_WIDTH(16), .RATIO(2), .DEPTH_WIDTH(2)) ia ();
  sfifo_wconv_prefetch_if #(.WR_DATA_WIDTH(8),  .RATIO(4), .DEPTH_WIDTH(2)) ib ();
  sfifo_wconv_prefetch_if #(.WR_DATA_WIDTH(8),  .RATIO(1), .DEPTH_WIDTH(2)) ic ();

`ifdef SFIFO_WCONV_FLUSH_EN
  logic flush_a;
  logic flush_off;
`endif

  sfifo_wconv_prefetch #(.WR_DATA_WIDTH(16), .RATIO(2), .DEPTH_WIDTH(2), .AF_THRESH(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SFIFO_WCONV_FLUSH_EN
    .flush (flush_a),
`endif
    .bus   (ia)
  );

  sfifo_wconv_prefetch #(.WR_DATA_WIDTH(8), .RATIO(4), .DEPTH_WIDTH(2), .AF_THRESH(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SFIFO_WCONV_FLUSH_EN
    .flush (flush_off),
`endif
    .bus   (ib)
  );

  sfifo_wconv_prefetch #(.WR_DATA_WIDTH(8), .RATIO(1), .DEPTH_WIDTH(2), .AF_THRESH(3)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SFIFO_WCONV_FLUSH_EN
    .flush (flush_off),
`endif
    .bus   (ic)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (ia.rd_vld !== 1'b0) begin failures++; $display("FAIL rst_rd_vld got=%b exp=0", ia.rd_vld); end
    checks++; if (ia.wr_vld !== 1'b0) begin failures++; $display("FAIL rst_wr_vld got=%b exp=0", ia.wr_vld); end
    checks++; if (ia.level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", ia.level); end
    checks++; if (ia.almost_full !== 1'b0) begin failures++; $display("FAIL rst_af got=%b exp=0", ia.almost_full); end
    checks++; if (ia.rd_data !== 32'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", ia.rd_data); end
    rst_n = 1'b1;
    checks++; if (ia.wr_vld !== 1'b0) begin failures++; $display("FAIL rel_wr_vld_early got=%b exp=0", ia.wr_vld); end
    tick();
    checks++; if (ia.wr_vld !== 1'b1) begin failures++; $display("FAIL rel_wr_vld got=%b exp=1", ia.wr_vld); end
    checks++; if (ib.wr_vld !== 1'b1) begin failures++; $display("FAIL rel_wr_vld_b got=%b exp=1", ib.wr_vld); end
    checks++; if (ia.rd_vld !== 1'b0) begin failures++; $display("FAIL rel_rd_vld got=%b exp=0", ia.rd_vld); end
    checks++; if (ia.level !== 3'd0) begin failures++; $display("FAIL rel_level got=%0d exp=0", ia.level); end
  endtask

  task automatic test_packing();
    ia.wr_en = 1'b1; ia.wr_data = 16'h1111;
    tick();
    ia.wr_data = 16'h2222;
    tick();
    ia.wr_en = 1'b0;
    checks++; if (ia.level !== 3'd1) begin failures++; $display("FAIL pack_level_push got=%0d exp=1", ia.level); end
    checks++; if (ia.rd_vld !== 1'b0) begin failures++; $display("FAIL pack_rd_vld_early got=%b exp=0", ia.rd_vld); end
    tick();
    checks++; if (ia.rd_vld !== 1'b1) begin failures++; $display("FAIL pack_rd_vld got=%b exp=1", ia.rd_vld); end
    checks++; if (ia.rd_data !== 32'h2222_1111) begin failures++; $display("FAIL pack_data got=%h exp=22221111", ia.rd_data); end
    checks++; if (ia.level !== 3'd1) begin failures++; $display("FAIL pack_level got=%0d exp=1", ia.level); end
    ia.rd_en = 1'b1;
    tick();
    ia.rd_en = 1'b0;
    checks++; if (ia.rd_vld !== 1'b0) begin failures++; $display("FAIL pack_pop_rd_vld got=%b exp=0", ia.rd_vld); end
    checks++; if (ia.level !== 3'd0) begin failures++; $display("FAIL pack_pop_level got=%0d exp=0", ia.level); end
  endtask

  task automatic test_fill();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      ia.wr_en = 1'b1; ia.wr_data = 16'(16'hA000 + i);
      checks++; if (ia.wr_vld !== 1'b1) begin failures++; $display("FAIL fill_wr_vld_%0d got=%b exp=1", i, ia.wr_vld); end
      tick();
    end
    ia.wr_data = 16'hDEAD;
    tick();
    ia.wr_en = 1'b0;
    checks++; if (ia.level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", ia.level); end
    checks++; if (ia.wr_vld !== 1'b0) begin failures++; $display("FAIL full_wr_vld got=%b exp=0", ia.wr_vld); end
    checks++; if (ia.almost_full !== 1'b1) begin failures++; $display("FAIL full_af got=%b exp=1", ia.almost_full); end
    checks++; if (ia.rd_data !== 32'hA001_A000) begin failures++; $display("FAIL full_head got=%h exp=a001a000", ia.rd_data); end
    ia.rd_en = 1'b1;
    #1;
    checks++; if (ia.wr_vld !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle got=%b exp=0", ia.wr_vld); end
    tick();
    ia.rd_en = 1'b0;
    checks++; if (ia.wr_vld !== 1'b1) begin failures++; $display("FAIL full_pop_wr_vld got=%b exp=1", ia.wr_vld); end
    checks++; if (ia.level !== 3'd3) begin failures++; $display("FAIL full_pop_level got=%0d exp=3", ia.level); end
    checks++; if (ia.almost_full !== 1'b1) begin failures++; $display("FAIL full_pop_af got=%b exp=1", ia.almost_full); end
    for (int k = 1; k < 4; k++) begin
      exp = {16'(16'hA000 + 2*k + 1), 16'(16'hA000 + 2*k)};
      checks++; if (ia.rd_vld !== 1'b1 || ia.rd_data !== exp) begin failures++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, ia.rd_vld, ia.rd_data, exp); end
      ia.rd_en = 1'b1;
      tick();
    end
    ia.rd_en = 1'b0;
    checks++; if (ia.level !== 3'd0 || ia.rd_vld !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", ia.level, ia.rd_vld); end
    checks++; if (ia.almost_full !== 1'b0) begin failures++; $display("FAIL drain_af got=%b exp=0", ia.almost_full); end
    // packer alignment must survive the ignored write
    ia.wr_en = 1'b1; ia.wr_data = 16'h1234;
    tick();
    ia.wr_data = 16'h5678;
    tick();
    ia.wr_en = 1'b0;
    tick();
    checks++; if (ia.rd_data !== 32'h5678_1234) begin failures++; $display("FAIL after_full_align got=%h exp=56781234", ia.rd_data); end
    ia.rd_en = 1'b1;
    tick();
    ia.rd_en = 1'b0;
  endtask

  task automatic test_stream();
    int n, k, cyc;
    logic acc;
    logic [31:0] exp;
    n = 0; k = 0; cyc = 0;
    ib.rd_en = 1'b1;
    while ((k < 64) && (cyc < 600)) begin
      ib.wr_en   = (n < 256);
      ib.wr_data = 8'(n);
      if (ib.rd_vld) begin
        exp = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
        checks++; if (ib.rd_data !== exp) begin failures++; $display("FAIL stream_word_%0d got=%h exp=%h", k, ib.rd_data, exp); end
        k++;
      end
      acc = ib.wr_en && ib.wr_vld;
      tick();
      cyc++;
      if (acc) n++;
    end
    ib.wr_en = 1'b0;
    ib.rd_en = 1'b0;
    checks++; if (k != 64) begin failures++; $display("FAIL stream_count got=%0d exp=64", k); end
    checks++; if (ib.level !== 3'd0 || ib.rd_vld !== 1'b0) begin failures++; $display("FAIL stream_end got=%0d/%b exp=0/0", ib.level, ib.rd_vld); end
  endtask

  task automatic test_back_to_back();
    int n, k, cyc, first, gaps;
    logic acc;
    n = 0; k = 0; cyc = 0; first = -1; gaps = 0;
    ic.rd_en = 1'b1;
    while ((k < 20) && (cyc < 100)) begin
      ic.wr_en   = (n < 20);
      ic.wr_data = 8'(n + 64);
      if (ic.rd_vld) begin
        if (first < 0) first = cyc;
        checks++; if (ic.rd_data !== 8'(k + 64)) begin failures++; $display("FAIL b2b_word_%0d got=%h exp=%h", k, ic.rd_data, 8'(k + 64)); end
        k++;
      end else if (first >= 0) begin
        gaps++;
      end
      acc = ic.wr_en && ic.wr_vld;
      tick();
      cyc++;
      if (acc) n++;
    end
    ic.wr_en = 1'b0;
    ic.rd_en = 1'b0;
    checks++; if (k != 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", k); end
    checks++; if (first != 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", first); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_partial_reset();
    for (int i = 0; i < 7; i++) begin
      ib.wr_en = 1'b1;
      ib.wr_data = (i < 4) ? 8'(8'h10 + i) : 8'(8'hA1 + i - 4);
      tick();
    end
    ib.wr_en = 1'b0;
    checks++; if (ib.level !== 3'd1 || ib.rd_data !== 32'h1312_1110) begin failures++; $display("FAIL part_pre got=%0d/%h exp=1/13121110", ib.level, ib.rd_data); end
    rst_n = 1'b0;
    #2;
    checks++; if (ib.level !== 3'd0) begin failures++; $display("FAIL part_rst_level got=%0d exp=0", ib.level); end
    checks++; if (ib.rd_vld !== 1'b0) begin failures++; $display("FAIL part_rst_rd_vld got=%b exp=0", ib.rd_vld); end
    checks++; if (ib.wr_vld !== 1'b0) begin failures++; $display("FAIL part_rst_wr_vld got=%b exp=0", ib.wr_vld); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (ib.wr_vld !== 1'b1) begin failures++; $display("FAIL part_rel_wr_vld got=%b exp=1", ib.wr_vld); end
    for (int i = 0; i < 4; i++) begin
      ib.wr_en = 1'b1; ib.wr_data = 8'(8'hB0 + i);
      tick();
    end
    ib.wr_en = 1'b0;
    tick();
    checks++; if (ib.rd_vld !== 1'b1 || ib.rd_data !== 32'hB3B2_B1B0) begin failures++; $display("FAIL part_new_word got=%b/%h exp=1/b3b2b1b0", ib.rd_vld, ib.rd_data); end
    checks++; if (ib.level !== 3'd1) begin failures++; $display("FAIL part_new_level got=%0d exp=1", ib.level); end
    ib.rd_en = 1'b1;
    tick();
    ib.rd_en = 1'b0;
    checks++; if (ib.level !== 3'd0) begin failures++; $display("FAIL part_pop_level got=%0d exp=0", ib.level); end
  endtask

`ifdef SFIFO_WCONV_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      ia.wr_en = 1'b1; ia.wr_data = 16'(16'hC000 + i);
      tick();
    end
    ia.wr_en = 1'b0;
    checks++; if (ia.level !== 3'd3) begin failures++; $display("FAIL flush_pre_level got=%0d exp=3", ia.level); end
    flush_a = 1'b1; ia.wr_en = 1'b1; ia.wr_data = 16'hFFFF; ia.rd_en = 1'b1;
    tick();
    flush_a = 1'b0; ia.wr_en = 1'b0; ia.rd_en = 1'b0;
    checks++; if (ia.level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", ia.level); end
    checks++; if (ia.rd_vld !== 1'b0) begin failures++; $display("FAIL flush_rd_vld got=%b exp=0", ia.rd_vld); end
    checks++; if (ia.wr_vld !== 1'b0) begin failures++; $display("FAIL flush_wr_vld got=%b exp=0", ia.wr_vld); end
    checks++; if (ia.almost_full !== 1'b0) begin failures++; $display("FAIL flush_af got=%b exp=0", ia.almost_full); end
    tick();
    checks++; if (ia.wr_vld !== 1'b1 || ia.level !== 3'd0 || ia.rd_vld !== 1'b0) begin failures++; $display("FAIL flush_after got=%b/%0d/%b exp=1/0/0", ia.wr_vld, ia.level, ia.rd_vld); end
    ia.wr_en = 1'b1; ia.wr_data = 16'hD000;
    tick();
    ia.wr_data = 16'hD001;
    tick();
    ia.wr_en = 1'b0;
    tick();
    checks++; if (ia.rd_data !== 32'hD001_D000) begin failures++; $display("FAIL flush_realign got=%h exp=d001d000", ia.rd_data); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ia.wr_en = 1'b0; ia.wr_data = '0; ia.rd_en = 1'b0;
    ib.wr_en = 1'b0; ib.wr_data = '0; ib.rd_en = 1'b0;
    ic.wr_en = 1'b0; ic.wr_data = '0; ic.rd_en = 1'b0;
`ifdef SFIFO_WCONV_FLUSH_EN
    flush_a = 1'b0;
    flush_off = 1'b0;
`endif
    test_reset();
    test_packing();
    test_fill();
    test_stream();
    test_back_to_back();
    test_partial_reset();
`ifdef SFIFO_WCONV_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
